// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) arithmetic, field constants and the iterative FSM state type.
package aes_pkg;

  localparam logic [7:0] GF_09   = 8'h09;
  localparam logic [7:0] GF_0B   = 8'h0b;
  localparam logic [7:0] GF_0D   = 8'h0d;
  localparam logic [7:0] GF_0E   = 8'h0e;
  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply: each set bit of b adds the matching xtime power of a.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = '0;
    pow = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ pow;
      pow = xtime(pow);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column, row 0 byte in bits [31:24].
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col;

  assign mixed[31:24] = gf_mul(a0, GF_0E) ^ gf_mul(a1, GF_0B) ^ gf_mul(a2, GF_0D) ^ gf_mul(a3, GF_09);
  assign mixed[23:16] = gf_mul(a0, GF_09) ^ gf_mul(a1, GF_0E) ^ gf_mul(a2, GF_0B) ^ gf_mul(a3, GF_0D);
  assign mixed[15:8]  = gf_mul(a0, GF_0D) ^ gf_mul(a1, GF_09) ^ gf_mul(a2, GF_0E) ^ gf_mul(a3, GF_0B);
  assign mixed[7:0]   = gf_mul(a0, GF_0B) ^ gf_mul(a1, GF_0D) ^ gf_mul(a2, GF_09) ^ gf_mul(a3, GF_0E);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: loads a state, transforms COLS_PER_CYCLE columns per cycle in place.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

  state_t       state, next_state;
  logic [1:0]   cnt;
  logic [127:0] work, next_work;
  logic         last_group;

  logic [1:0]   col_idx  [COLS_PER_CYCLE];
  logic [31:0]  col_word [COLS_PER_CYCLE];
  logic [31:0]  col_res  [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g]  = cnt + 2'(g);
    assign col_word[g] = work[{col_idx[g], 5'b0} +: 32];

    inv_mix_column_word u_word (
      .col   (col_word[g]),
      .mixed (col_res[g])
    );
  end

  always_comb begin
    next_work = work;
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      next_work[{col_idx[g], 5'b0} +: 32] = col_res[g];
    end
  end

  assign last_group = (cnt == LAST_IDX);
  assign out_data   = work;

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = BUSY;
      end
      BUSY: begin
        if (last_group) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Counter holds on the final group rather than advancing, so it never wraps mid-operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            cnt  <= '0;
          end
        end
        BUSY: begin
          work <= next_work;
          if (!last_group) cnt <= cnt + STEP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed and round-trip checks of inv_mix_columns_iter at 1, 2 and 4 columns per cycle.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]));

  // Forward MixColumns reference, rows {02,03,01,01} rotated.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] fwd_state(input logic [127:0] s);
    return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one state, wait for the result, take it. lat = edges from acceptance to out_valid (99 on timeout).
  task automatic run_op(input int k, input logic [127:0] d, output logic [127:0] r, output int lat);
    int w;
    w = 0;
    while (!in_ready[k] && w < 20) begin tick(); w++; end
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    tick();
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 20) begin tick(); lat++; end
    if (!out_valid[k] || w >= 20) lat = 99;
    r = out_data[k];
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b1;
      in_data[k]   = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
      out_ready[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || out_data[k] !== 128'h0) begin
        failures++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%h, want 1 0 0", k, in_ready[k], out_valid[k], out_data[k]);
      end
      in_valid[k] = 1'b0;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready[0] !== 1'b1 || out_data[0] !== 128'h0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_data=%h, want 1 0", in_ready[0], out_data[0]);
    end
  endtask

  task automatic test_vectors();
    logic [127:0] vin  [3];
    logic [127:0] vexp [3];
    logic [127:0] r;
    int lat;
    vin[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    vexp[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    vin[1]  = {4{32'hd5d5d7d6}};
    vexp[1] = {4{32'hd4d4d4d5}};
    vin[2]  = {4{32'h4d7ebdf8}};
    vexp[2] = {4{32'h2d26314c}};
    for (int v = 0; v < 3; v++) begin
      run_op(0, vin[v], r, lat);
      checks++;
      if (r !== vexp[v]) begin
        failures++;
        $display("FAIL vector%0d data: got %h want %h", v, r, vexp[v]);
      end
      checks++;
      if (lat != 4) begin
        failures++;
        $display("FAIL vector%0d latency: got %0d want 4", v, lat);
      end
      checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
        failures++;
        $display("FAIL vector%0d idle_after: in_ready=%b out_valid=%b want 1 0", v, in_ready[0], out_valid[0]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [127:0] r;
    int lat;
    // Stray in_valid during BUSY must not reload the working register.
    fork
      run_op(0, {4{32'hd5d5d7d6}}, r, lat);
      begin
        tick();
        #2;
        in_valid[0] = 1'b1;
        in_data[0]  = 128'h11111111_22222222_33333333_44444444;
        tick();
        tick();
        in_valid[0] = 1'b0;
      end
    join
    checks++;
    if (r !== {4{32'hd4d4d4d5}}) begin
      failures++;
      $display("FAIL ignore_busy: got %h want %h", r, {4{32'hd4d4d4d5}});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] expv;
    int lat;
    expv = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    in_valid[0] = 1'b1;
    in_data[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    tick();
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== expv) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b data=%h want 1 0 %h", c, out_valid[0], in_ready[0], out_data[0], expv);
      end
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] r;
    int lat;
    in_valid[0] = 1'b1;
    in_data[0]  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    tick();
    in_valid[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== 128'h0) begin
      failures++;
      $display("FAIL mid_busy_reset: in_ready=%b out_valid=%b data=%h want 1 0 0", in_ready[0], out_valid[0], out_data[0]);
    end
    run_op(0, {4{32'h4d7ebdf8}}, r, lat);
    checks++;
    if (r !== {4{32'h2d26314c}} || lat != 4) begin
      failures++;
      $display("FAIL after_reset_op: got %h lat %0d want %h lat 4", r, lat, {4{32'h2d26314c}});
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig, r;
    int lat;
    int want_lat;
    int bad;
    for (int k = 0; k < 3; k++) begin
      want_lat = (k == 0) ? 4 : (k == 1) ? 2 : 1;
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
        orig = {$urandom, $urandom, $urandom, $urandom};
        run_op(k, fwd_state(orig), r, lat);
        checks++;
        if (r !== orig || lat != want_lat) begin
          failures++;
          bad++;
          if (bad <= 5)
            $display("FAIL round_trip[%0d] #%0d: got %h lat %0d want %h lat %0d", k, n, r, lat, orig, want_lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_busy();
    test_backpressure();
    test_reset_mid_busy();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
